// File: rtl/fetch_ram_wr_ctrl_pkg.sv
// Shared definitions for the fetch buffer RAM write-side controller:
// default geometry, FSM state encoding and half-line write-enable patterns.
package fetch_ram_wr_ctrl_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_DEPTH       = 208;
  localparam int DEF_ADDR_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } wr_state_t;

  localparam logic [1:0] WE_LO = 2'b01;
  localparam logic [1:0] WE_HI = 2'b10;

endpackage

// File: rtl/fetch_ram_wr_ctrl.sv
// Packs 4-pixel beats from the fetch interface into 8-pixel RAM lines, low half
// first, walking a wrapping address window and pulsing done_o at task end.
module fetch_ram_wr_ctrl
  import fetch_ram_wr_ctrl_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [ADDR_W-1:0]        num_lines_i,
  input  logic                     dat_vld_i,
  input  logic [4*PIXEL_WIDTH-1:0] dat_i,
  output logic                     dat_rdy_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W-1:0]        lines_o,
  output logic [1:0]               a_we,
  output logic [ADDR_W-1:0]        a_addr,
  output logic [8*PIXEL_WIDTH-1:0] a_data_i
);

  wr_state_t         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] remaining;
  logic              half;
  logic              hs;

  // Pointer never enters the unused address range DEPTH..2^ADDR_W-1.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  assign hs = dat_vld_i & dat_rdy_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      half      <= 1'b0;
      dat_rdy_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      lines_o   <= '0;
      a_we      <= '0;
      a_addr    <= '0;
      a_data_i  <= '0;
    end else begin
      a_we   <= '0;
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            lines_o <= '0;
            if (num_lines_i != '0) begin
              state     <= ST_LOAD;
              wr_ptr    <= base_addr_i;
              half      <= 1'b0;
              remaining <= num_lines_i;
              dat_rdy_o <= 1'b1;
              busy_o    <= 1'b1;
            end else begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (hs) begin
            a_we     <= half ? WE_HI : WE_LO;
            a_addr   <= wr_ptr;
            a_data_i <= {dat_i, dat_i};
            half     <= ~half;
            // A line is complete only once its high half has been accepted.
            if (half) begin
              wr_ptr    <= next_ptr(wr_ptr);
              lines_o   <= lines_o + ADDR_W'(1);
              remaining <= remaining - ADDR_W'(1);
              if (remaining == ADDR_W'(1)) begin
                state     <= ST_DONE;
                dat_rdy_o <= 1'b0;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ram_wr_ctrl.sv
// Randomized scoreboard bench for fetch_ram_wr_ctrl: expected RAM writes are
// queued per task from a line/address model and popped by a negedge monitor.
module tb_fetch_ram_wr_ctrl;

  localparam int DEPTH = 208;

  typedef struct {
    logic [1:0]  we;
    logic [7:0]  addr;
    logic [63:0] data;
    logic        last;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  base_addr_i;
  logic [7:0]  num_lines_i;
  logic        dat_vld_i;
  logic [31:0] dat_i;
  logic        dat_rdy_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  lines_o;
  logic [1:0]  a_we;
  logic [7:0]  a_addr;
  logic [63:0] a_data_i;

  wr_t exp_q[$];
  int  exp_zero_done = 0;
  int  tests = 0;
  int  fails = 0;

  fetch_ram_wr_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_lines_i(num_lines_i), .dat_vld_i(dat_vld_i), .dat_i(dat_i),
    .dat_rdy_o(dat_rdy_o), .busy_o(busy_o), .done_o(done_o), .lines_o(lines_o),
    .a_we(a_we), .a_addr(a_addr), .a_data_i(a_data_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RAM write must be the next one the model predicted.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (a_we != 2'b00) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", {54'd0, a_we, a_addr}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_we", {62'd0, a_we}, {62'd0, e.we});
          checkOutput("wr_addr", {56'd0, a_addr}, {56'd0, e.addr});
          checkOutput("wr_data", a_data_i, e.data);
          checkOutput("wr_done", {63'd0, done_o}, {63'd0, e.last});
        end
      end else if (done_o) begin
        checkOutput("zero_task_done", {63'd0, exp_zero_done > 0}, 64'd1);
        if (exp_zero_done > 0) exp_zero_done--;
      end
    end
  end

  // Model: line i of a task lands at (base+i) mod DEPTH, low beat then high beat.
  task automatic pushTask(input int base, input int n, input logic [31:0] beats[$]);
    for (int i = 0; i < n; i++) begin
      wr_t lo, hi;
      lo.we = 2'b01; lo.addr = 8'((base + i) % DEPTH);
      lo.data = {beats[2*i], beats[2*i]}; lo.last = 1'b0;
      hi.we = 2'b10; hi.addr = lo.addr;
      hi.data = {beats[2*i+1], beats[2*i+1]}; hi.last = (i == n - 1);
      exp_q.push_back(lo);
      exp_q.push_back(hi);
    end
  endtask

  // Sends beats [0..count-1]; each call to this starts at a negedge.
  task automatic sendBeats(input logic [31:0] beats[$], input int count,
                           input int stall_pct, input bit mid_start);
    for (int k = 0; k < count; k++) begin
      bit sent = 0;
      int guard = 0;
      while (!sent && guard < 60) begin
        @(negedge clk);
        start_i = 1'b0;
        if (mid_start && k == 2) begin
          start_i = 1'b1; base_addr_i = 8'd50; num_lines_i = 8'd7;
        end
        dat_vld_i = ($urandom_range(99) >= stall_pct);
        dat_i = dat_vld_i ? beats[k] : $urandom;
        if (dat_vld_i && dat_rdy_o) sent = 1;
        guard++;
      end
      if (!sent) begin
        checkOutput("beat_timeout", 64'd0, 64'd1);
        return;
      end
    end
  endtask

  task automatic applyStimulus(input int base, input int n, input int stall_pct, input bit mid_start);
    logic [31:0] beats[$];
    int g = 0;
    for (int i = 0; i < 2 * n; i++) beats.push_back($urandom);
    pushTask(base, n, beats);
    start_i = 1'b1; base_addr_i = 8'(base); num_lines_i = 8'(n);
    sendBeats(beats, 2 * n, stall_pct, mid_start);
    @(negedge clk);
    dat_vld_i = 1'b0; start_i = 1'b0;
    while (!done_o && g < 10) begin
      @(negedge clk);
      g++;
    end
    checkOutput("done_seen", {63'd0, done_o}, 64'd1);
    // Start during DONE must be dropped.
    start_i = 1'b1; base_addr_i = 8'd3; num_lines_i = 8'd5;
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("lines_final", {56'd0, lines_o}, 64'(n));
    checkOutput("idle_flags", {62'd0, busy_o, dat_rdy_o}, 64'd0);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    forever begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
    end
  end

  initial begin
    logic [31:0] beats[$];
    rst = 1'b1; start_i = 0; base_addr_i = 0; num_lines_i = 0; dat_vld_i = 0; dat_i = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {dat_rdy_o, busy_o, done_o, lines_o, a_we, a_addr, 43'd0},
                64'd0);
    checkOutput("reset_data", a_data_i, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic, wrap, stalls, mid-task start");
    applyStimulus(0, 2, 0, 0);
    applyStimulus(206, 4, 0, 0);
    applyStimulus(int'($urandom_range(DEPTH - 1)), 3, 50, 0);
    applyStimulus(100, 3, 0, 1);

    $display("[TB] zero-length task");
    exp_zero_done++;
    start_i = 1'b1; base_addr_i = 8'd77; num_lines_i = 8'd0; dat_vld_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("zero_rdy", {62'd0, dat_rdy_o, busy_o}, 64'd0);
    @(negedge clk);
    dat_vld_i = 1'b0;
    checkOutput("zero_lines", {56'd0, lines_o}, 64'd0);
    checkOutput("zero_done_count", 64'(exp_zero_done), 64'd0);

    $display("[TB] reset mid-task");
    for (int i = 0; i < 8; i++) beats.push_back($urandom);
    pushTask(20, 4, beats);
    start_i = 1'b1; base_addr_i = 8'd20; num_lines_i = 8'd4;
    sendBeats(beats, 3, 0, 0);
    @(negedge clk);
    dat_vld_i = 1'b0;
    @(negedge clk);
    checkOutput("writes_before_reset", 64'(exp_q.size()), 64'd5);
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("async_reset", {dat_rdy_o, busy_o, done_o, lines_o, a_we, a_addr, 43'd0}, 64'd0);
    checkOutput("async_reset_data", a_data_i, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(10, 2, 0, 0);

    $display("[TB] random back-to-back tasks");
    for (int t = 0; t < 10; t++)
      applyStimulus(int'($urandom_range(DEPTH - 1)), int'($urandom_range(8, 1)), 30, 0);

    repeat (4) @(negedge clk);
    checkOutput("final_queue", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
